// File: rtl/dac_sched_pkg.sv
// Shared definitions for the DAC update scheduler.
//   FRAME_W      width of one serialiser frame
//   CMD_*        DAC command nibbles placed in frame[23:20]
//   state_e      scheduler FSM states
//   build_frame  packs {cmd, channel index, value} into one frame
package dac_sched_pkg;

   localparam int FRAME_W = 24;

   localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
   localparam logic [3:0] CMD_WRITE_BUF    = 4'h0;
   localparam logic [3:0] CMD_UPDATE_ALL   = 4'h2;

   // Channel-index nibble used by the broadcast update frame.
   localparam logic [3:0] UPDATE_ALL_IDX   = 4'hF;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SEND       = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3,
      GAP        = 3'd4
   } state_e;

   function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                      input logic [3:0]  idx,
                                                      input logic [15:0] value);
      return {cmd, idx, value};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req          request vector, one bit per channel
//   ptr          index with highest priority this cycle
//   grant_valid  1 when any request is set
//   grant_idx    first requesting index at or after ptr, wrapping at N
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic             grant_valid,
   output logic [PTR_W-1:0] grant_idx
);

   localparam logic [PTR_W:0] N_L = (PTR_W + 1)'(N);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;

   // Scan from the farthest offset down to offset 0 so the nearest request
   // after ptr is the last one written and therefore wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      idx         = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (PTR_W + 1)'(k);
         if (sum >= N_L) begin
            sum = sum - N_L;
         end
         idx = sum[PTR_W-1:0];
         if (req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/dac_update_scheduler.sv
// Shares one 24-bit DAC SPI serialiser between NUM_CH channels. Each channel's
// latest value is latched, a pending channel is picked round-robin, its frame
// is registered onto dac_data_out and a one-cycle send pulse is issued. The
// serialiser chip-select (active low) marks frame start and end; a fixed idle
// gap follows every frame.
//
// Ports
//   clock_in         system clock
//   reset            asynchronous, active-low reset
//   ch_valid         per-channel one-cycle update strobe
//   ch_data          channel i value at [i*DATA_W +: DATA_W]
//   dac_data_out     frame to serialiser, held from grant to next grant
//   dac_send_out     one-cycle send pulse
//   dac_cs_in        serialiser chip-select, active low, same clock domain
//   busy_out         1 whenever the FSM is not IDLE
//   timeout_err_out  sticky: chip-select never went low after a send
//
// Build option DAC_SYNC_UPDATE_EN: channel frames only write the DAC input
// buffers; once no channel is pending a single update-all frame is sent so
// every output changes together.
//
// Handshake with the serialiser: dac_send_out is a single-cycle request with
// dac_data_out already stable; the serialiser acknowledges by driving
// dac_cs_in low, and the frame is complete when dac_cs_in returns high.
module dac_update_scheduler
   import dac_sched_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int DATA_W        = 16,
   parameter int GAP_CYCLES    = 4,
   parameter int START_TIMEOUT = 16
) (
   input  logic                     clock_in,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [FRAME_W-1:0]       dac_data_out,
   output logic                     dac_send_out,
   input  logic                     dac_cs_in,
   output logic                     busy_out,
   output logic                     timeout_err_out
);

   localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TMR_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [PTR_W-1:0] LAST_CH    = PTR_W'(NUM_CH - 1);
   // The send cycle counts as the first clock of the start window, so
   // WAIT_START itself lasts START_TIMEOUT-1 cycles.
   localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 2);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);

`ifdef DAC_SYNC_UPDATE_EN
   localparam logic [3:0] CH_CMD = CMD_WRITE_BUF;
`else
   localparam logic [3:0] CH_CMD = CMD_WRITE_UPDATE;
`endif

   state_e               state_q, state_d;
   logic [DATA_W-1:0]    value_q [NUM_CH];
   logic [DATA_W-1:0]    value_d [NUM_CH];
   logic [NUM_CH-1:0]    pending_q, pending_d;
   logic [PTR_W-1:0]     rr_q, rr_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 err_q, err_d;
`ifdef DAC_SYNC_UPDATE_EN
   logic                 dirty_q, dirty_d;
`endif

   logic                 grant_valid;
   logic [PTR_W-1:0]     grant_idx;
   logic [NUM_CH-1:0]    grant_clr;
   logic [15:0]          grant_val;

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .req         (pending_q),
      .ptr         (rr_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Latest value wins; a strobe always overwrites the stored value.
   always_comb begin
      value_d = value_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_valid[i]) begin
            value_d[i] = ch_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Value going out uses the register contents, so a strobe in the grant
   // cycle is stored for the next round rather than sent now.
   always_comb begin
      grant_val = 16'(value_q[grant_idx]);
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      rr_d      = rr_q;
      frame_d   = frame_q;
      err_d     = err_q;
      grant_clr = '0;
`ifdef DAC_SYNC_UPDATE_EN
      dirty_d   = dirty_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               frame_d              = build_frame(CH_CMD, 4'(grant_idx), grant_val);
               grant_clr[grant_idx] = 1'b1;
               rr_d                 = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
`ifdef DAC_SYNC_UPDATE_EN
               dirty_d              = 1'b1;
`endif
               state_d              = SEND;
            end
`ifdef DAC_SYNC_UPDATE_EN
            else if (dirty_q) begin
               // Broadcast update leaves rr_q alone so rotation is unaffected.
               frame_d = build_frame(CMD_UPDATE_ALL, UPDATE_ALL_IDX, 16'h0000);
               dirty_d = 1'b0;
               state_d = SEND;
            end
`endif
         end
         SEND: begin
            timer_d = '0;
            state_d = WAIT_START;
         end
         WAIT_START: begin
            if (!dac_cs_in) begin
               state_d = WAIT_DONE;
            end else if (timer_q == START_LAST) begin
               err_d   = 1'b1;
               timer_d = '0;
               state_d = GAP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (dac_cs_in) begin
               timer_d = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (timer_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A strobe in the grant cycle keeps the channel pending (set wins).
      pending_d = (pending_q & ~grant_clr) | ch_valid;
   end

   // State register.
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers.
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            value_q[i] <= '0;
         end
         pending_q <= '0;
         rr_q      <= '0;
         timer_q   <= '0;
         frame_q   <= '0;
         err_q     <= 1'b0;
`ifdef DAC_SYNC_UPDATE_EN
         dirty_q   <= 1'b0;
`endif
      end else begin
         value_q   <= value_d;
         pending_q <= pending_d;
         rr_q      <= rr_d;
         timer_q   <= timer_d;
         frame_q   <= frame_d;
         err_q     <= err_d;
`ifdef DAC_SYNC_UPDATE_EN
         dirty_q   <= dirty_d;
`endif
      end
   end

   // FSM outputs.
   always_comb begin
      dac_send_out = (state_q == SEND);
      busy_out     = (state_q != IDLE);
   end

   assign dac_data_out    = frame_q;
   assign timeout_err_out = err_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler: directed stimulus, a chip-select responder
// emulating a 24-bit-time serialiser, an abstract channel model that predicts
// every frame, and a queue of hand-computed frames expected in order.
module tb_dac_update_scheduler;

   localparam int NUM_CH        = 4;
   localparam int DATA_W        = 16;
   localparam int GAP_CYCLES    = 4;
   localparam int START_TIMEOUT = 16;

`ifdef DAC_SYNC_UPDATE_EN
   localparam bit         SYNC   = 1'b1;
   localparam logic [3:0] CMD_CH = 4'h0;
`else
   localparam bit         SYNC   = 1'b0;
   localparam logic [3:0] CMD_CH = 4'h3;
`endif
   localparam logic [23:0] UPD_FRAME = 24'h2F0000;

   // ---------------- clock / reset ----------------
   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_CH-1:0]        ch_valid = '0;
   logic [NUM_CH*DATA_W-1:0] ch_data = '0;
   logic [23:0]              dac_data_out;
   logic                     dac_send_out;
   logic                     dac_cs_in = 1'b1;
   logic                     busy_out;
   logic                     timeout_err_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dac_update_scheduler #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .GAP_CYCLES(GAP_CYCLES), .START_TIMEOUT(START_TIMEOUT)
   ) dut (
      .clock_in        (clk),
      .reset           (rst_n),
      .ch_valid        (ch_valid),
      .ch_data         (ch_data),
      .dac_data_out    (dac_data_out),
      .dac_send_out    (dac_send_out),
      .dac_cs_in       (dac_cs_in),
      .busy_out        (busy_out),
      .timeout_err_out (timeout_err_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [23:0] lit(input logic [3:0] idx, input logic [15:0] v);
      return {CMD_CH, idx, v};
   endfunction

   // ---------------- serialiser chip-select responder ----------------
   bit cs_en = 1'b1;
   int cs_rise_cyc = 0;

   initial forever begin
      @(negedge clk);
      if (dac_send_out && cs_en && rst_n) begin
         repeat (2) @(posedge clk);
         #1 dac_cs_in = 1'b0;
         repeat (24) @(posedge clk);
         #1 dac_cs_in = 1'b1;
         cs_rise_cyc = cyc;
      end
   end

   // ---------------- abstract model ----------------
   logic [NUM_CH-1:0] m_pend = '0;
   logic [NUM_CH-1:0] m_pend_prev = '0;
   logic [NUM_CH-1:0] m_valid_last = '0;
   logic [15:0]       m_val [NUM_CH];
   logic [15:0]       m_val_prev [NUM_CH];
   int                m_rr = 0;
   bit                m_dirty = 1'b0;
   logic [23:0]       m_frame = '0;

   // Channel state as seen at each clock edge; the previous snapshot is what
   // the scheduler decided on when it granted.
   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         m_pend = '0;
         m_pend_prev = '0;
         m_valid_last = '0;
         m_rr = 0;
         m_dirty = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_val[i] = '0;
            m_val_prev[i] = '0;
         end
      end else begin
         m_pend_prev = m_pend;
         m_val_prev = m_val;
         m_valid_last = ch_valid;
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i]) begin
               m_pend[i] = 1'b1;
               m_val[i] = ch_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // ---------------- scoreboard / compare ----------------
   logic [23:0] exp_q[$];
   int          send_count = 0;
   int          last_send_cyc = 0;
   bit          prev_send = 1'b0;
   int          sel;
   bit          found;
   logic [23:0] lit_exp;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         m_frame = '0;
         prev_send = 1'b0;
      end else begin
         if (dac_send_out) begin
            check("send_width", {31'd0, prev_send}, 32'd0);
            found = 1'b0;
            sel = 0;
            for (int k = 0; k < NUM_CH; k++) begin
               if (!found && m_pend_prev[(m_rr + k) % NUM_CH]) begin
                  found = 1'b1;
                  sel = (m_rr + k) % NUM_CH;
               end
            end
            if (found) begin
               m_frame = {CMD_CH, 4'(sel), m_val_prev[sel]};
               m_pend[sel] = m_valid_last[sel];
               m_rr = (sel + 1) % NUM_CH;
               if (SYNC) m_dirty = 1'b1;
            end else if (SYNC && m_dirty) begin
               m_frame = UPD_FRAME;
               m_dirty = 1'b0;
            end else begin
               checks++;
               errors++;
               $display("FAIL spurious_send: got send with frame %0h, expected no send", dac_data_out);
            end
            if (exp_q.size() > 0) begin
               lit_exp = exp_q.pop_front();
               check("frame_lit", {8'd0, dac_data_out}, {8'd0, lit_exp});
            end else begin
               checks++;
               errors++;
               $display("FAIL unexpected_send: got frame %0h, expected none queued", dac_data_out);
            end
            send_count++;
            last_send_cyc = cyc;
         end
         check("frame_model", {8'd0, dac_data_out}, {8'd0, m_frame});
         prev_send = dac_send_out;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse(input int idx, input logic [15:0] val, output int v);
      @(posedge clk);
      #1;
      ch_valid[idx] = 1'b1;
      ch_data[idx*DATA_W +: DATA_W] = val;
      v = cyc;
      @(posedge clk);
      #1;
      ch_valid = '0;
   endtask

   task automatic wait_send(input string name, input int budget, output int s);
      int start;
      start = send_count;
      s = -1;
      for (int i = 0; i < budget && send_count == start; i++) begin
         @(negedge clk);
         #1;
      end
      if (send_count == start) begin
         checks++;
         errors++;
         $display("FAIL %s: got no send, expected one within %0d cycles", name, budget);
      end else begin
         s = last_send_cyc;
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (n < 400 && (busy_out || m_pend != '0 || m_dirty)) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL %s: got busy after 400 cycles, expected idle", name);
      end
   endtask

   task automatic wait_cycle(input int n);
      while (cyc < n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic no_send_for(input string name, input int n);
      int start;
      start = send_count;
      repeat (n) @(negedge clk);
      #1;
      check(name, send_count - start, 0);
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic push_upd();
      if (SYNC) exp_q.push_back(UPD_FRAME);
   endtask

   // ---------------- directed tests ----------------
   int v, s, s1, s2, s3, base;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_data", {8'd0, dac_data_out}, 32'd0);
      check("rst_send", {31'd0, dac_send_out}, 32'd0);
      check("rst_busy", {31'd0, busy_out}, 32'd0);
      check("rst_err", {31'd0, timeout_err_out}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      no_send_for("quiet_after_reset", 10);

      // 1: single update, 2-clock latency, frame 32ABCD
      base = send_count;
      exp_q.push_back(lit(4'h2, 16'hABCD));
      push_upd();
      pulse(2, 16'hABCD, v);
      wait_send("t1_send", 20, s);
      check("t1_latency", s - v, 2);
      check("t1_frame", {8'd0, dac_data_out}, {8'd0, CMD_CH, 20'h2ABCD});
      check("t1_busy", {31'd0, busy_out}, 32'd1);
      wait_idle("t1_idle");
      check("t1_count", send_count - base, 1 + int'(SYNC));

      // 2: fairness from reset, all four at once -> 0,1,2,3
      reset_dut();
      base = send_count;
      for (int i = 0; i < NUM_CH; i++) exp_q.push_back(lit(4'(i), 16'(i + 1)));
      push_upd();
      @(posedge clk);
      #1;
      ch_valid = 4'hF;
      ch_data = {16'd4, 16'd3, 16'd2, 16'd1};
      v = cyc;
      @(posedge clk);
      #1 ch_valid = '0;
      wait_send("t2_send0", 20, s);
      check("t2_latency", s - v, 2);
      wait_send("t2_send1", 80, s1);
      check("t2_gap", s1 - cs_rise_cyc, GAP_CYCLES + 2);
      wait_send("t2_send2", 80, s2);
      wait_send("t2_send3", 80, s3);
      wait_idle("t2_idle");
      check("t2_count", send_count - base, 4 + int'(SYNC));

      // 3a: ch0 written three times while ch1 is in flight -> one ch0 frame
      base = send_count;
      exp_q.push_back(lit(4'h1, 16'h1234));
      exp_q.push_back(lit(4'h0, 16'h3333));
      push_upd();
      pulse(1, 16'h1234, v);
      wait_send("t3_send_ch1", 20, s);
      pulse(0, 16'h1111, v);
      pulse(0, 16'h2222, v);
      pulse(0, 16'h3333, v);
      wait_send("t3_send_ch0", 80, s2);
      check("t3_gap", s2 - cs_rise_cyc, GAP_CYCLES + 2);
      check("t3_frame", {8'd0, dac_data_out}, {8'd0, CMD_CH, 20'h03333});
      wait_idle("t3_idle");
      check("t3_count", send_count - base, 2 + int'(SYNC));

      // 3b: strobe in the grant cycle -> old value now, new value next round
      base = send_count;
      exp_q.push_back(lit(4'h0, 16'h0A0A));
      exp_q.push_back(lit(4'h0, 16'h0B0B));
      push_upd();
      @(posedge clk);
      #1;
      ch_valid[0] = 1'b1;
      ch_data[15:0] = 16'h0A0A;
      v = cyc;
      @(posedge clk);
      #1 ch_data[15:0] = 16'h0B0B;
      @(posedge clk);
      #1 ch_valid = '0;
      wait_send("t3b_send_a", 20, s);
      check("t3b_latency", s - v, 2);
      wait_send("t3b_send_b", 80, s2);
      wait_idle("t3b_idle");
      check("t3b_count", send_count - base, 2 + int'(SYNC));

      // 4: chip-select never asserts -> sticky error, next channel served
      cs_en = 1'b0;
      exp_q.push_back(lit(4'h3, 16'h4444));
      exp_q.push_back(lit(4'h1, 16'h5555));
      push_upd();
      pulse(3, 16'h4444, v);
      wait_send("t4_send", 20, s);
      pulse(1, 16'h5555, v);
      wait_cycle(s + START_TIMEOUT - 1);
      check("t4_err_before", {31'd0, timeout_err_out}, 32'd0);
      wait_cycle(s + START_TIMEOUT);
      check("t4_err_at", {31'd0, timeout_err_out}, 32'd1);
      check("t4_busy_gap", {31'd0, busy_out}, 32'd1);
      cs_en = 1'b1;
      wait_send("t4_next", 60, s2);
      check("t4_next_cycle", s2 - s, 21);
      wait_idle("t4_idle");
      check("t4_err_sticky", {31'd0, timeout_err_out}, 32'd1);

      // 5: reset during WAIT_DONE clears everything, no resend
      exp_q.push_back(lit(4'h2, 16'h7777));
      pulse(2, 16'h7777, v);
      wait_send("t5_send", 20, s);
      wait_cycle(s + 10);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("t5_data", {8'd0, dac_data_out}, 32'd0);
      check("t5_send_low", {31'd0, dac_send_out}, 32'd0);
      check("t5_busy", {31'd0, busy_out}, 32'd0);
      check("t5_err", {31'd0, timeout_err_out}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      no_send_for("t5_no_resend", 60);
      exp_q.push_back(lit(4'h1, 16'h0101));
      push_upd();
      pulse(1, 16'h0101, v);
      wait_send("t5_after", 20, s);
      check("t5_latency", s - v, 2);
      wait_idle("t5_idle");

`ifdef DAC_SYNC_UPDATE_EN
      // 6: buffered writes then a single update-all frame
      reset_dut();
      exp_q.push_back(24'h011111);
      exp_q.push_back(24'h033333);
      exp_q.push_back(24'h2F0000);
      @(posedge clk);
      #1;
      ch_valid = 4'b1010;
      ch_data[1*DATA_W +: DATA_W] = 16'h1111;
      ch_data[3*DATA_W +: DATA_W] = 16'h3333;
      @(posedge clk);
      #1 ch_valid = '0;
      wait_send("t6_ch1", 20, s);
      wait_send("t6_ch3", 80, s2);
      wait_send("t6_upd", 80, s3);
      wait_idle("t6_idle");
      no_send_for("t6_quiet", 80);
`endif

      check("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
